// File: rtl/quadra_arg_gen.sv
// quadra_arg_gen: argument sequencer for the quadra polynomial evaluator.
// Turns one sweep command (start, step, count) into a stream of x arguments,
// one per cycle, with valid/ready backpressure, abort and done reporting.
// Optional feature: define QUADRA_ARG_GEN_SAT_EN to clamp x at 2^XW-1 on
// overflow and raise the sticky sat flag; otherwise x wraps and sat is 0.
module quadra_arg_gen #(
    parameter int XW = 24,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [XW-1:0] cmd_start,
    input  logic [XW-1:0] cmd_step,
    input  logic [CW-1:0] cmd_count,
    input  logic          abort,
    output logic          x_valid,
    input  logic          x_ready,
    output logic [XW-1:0] x,
    output logic          x_last,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] beats,
    output logic          sat
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [XW-1:0] step_q, step_d;
    logic [CW-1:0] remaining_q, remaining_d;
    logic [CW-1:0] beats_q, beats_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic          beat;

`ifdef QUADRA_ARG_GEN_SAT_EN
    logic          sat_q, sat_d;
    logic [XW:0]   sum;
`endif

    // Next-state logic: command acceptance, per-beat advance, last-beat and abort termination
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        step_d      = step_q;
        remaining_d = remaining_q;
        beats_d     = beats_q;
        last_d      = last_q;
        done_d      = 1'b0;
        beat        = (state_q == RUN) && x_ready;
`ifdef QUADRA_ARG_GEN_SAT_EN
        sat_d       = sat_q;
        sum         = {1'b0, x_q} + {1'b0, step_q};
`endif

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    beats_d = '0;
`ifdef QUADRA_ARG_GEN_SAT_EN
                    sat_d   = 1'b0;
`endif
                    if (cmd_count != '0) begin
                        state_d     = RUN;
                        x_d         = cmd_start;
                        step_d      = cmd_step;
                        remaining_d = cmd_count;
                        last_d      = (cmd_count == CW'(1));
                    end else begin
                        // Empty sweep: report completion without ever presenting x
                        done_d = 1'b1;
                    end
                end
            end

            RUN: begin
                if (beat) begin
                    beats_d     = beats_q + CW'(1);
                    remaining_d = remaining_q - CW'(1);
                    last_d      = (remaining_q == CW'(2));
`ifdef QUADRA_ARG_GEN_SAT_EN
                    // Only an x that will actually be presented may clamp and flag sat
                    if ((sum[XW] || sat_q) && !last_q) begin
                        x_d   = '1;
                        sat_d = 1'b1;
                    end else begin
                        x_d = sum[XW-1:0];
                    end
`else
                    // Carry is discarded: x wraps modulo 2^XW
                    x_d = x_q + step_q;
`endif
                    if (last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
                // A beat coincident with abort has already been counted above
                if (abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset that discards any sweep
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            step_q      <= '0;
            remaining_q <= '0;
            beats_q     <= '0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            step_q      <= step_d;
            remaining_q <= remaining_d;
            beats_q     <= beats_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

`ifdef QUADRA_ARG_GEN_SAT_EN
    // Sticky saturation flag, cleared on reset or on the next accepted command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end

    assign sat = sat_q;
`else
    assign sat = 1'b0;
`endif

    assign cmd_ready = (state_q == IDLE);
    assign x_valid   = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign x         = x_q;
    assign x_last    = last_q && (state_q == RUN);
    assign done      = done_q;
    assign beats     = beats_q;

endmodule

// File: tb/tb_quadra_arg_gen.sv
// Testbench for quadra_arg_gen: directed sweeps with a scoreboard of expected
// x beats and expected done/beats results, checked by an independent monitor.
module tb_quadra_arg_gen;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_start;
    logic [23:0] cmd_step;
    logic [15:0] cmd_count;
    logic        abort;
    logic        x_valid;
    logic        x_ready;
    logic [23:0] x;
    logic        x_last;
    logic        busy;
    logic        done;
    logic [15:0] beats;
    logic        sat;

    int checks = 0;
    int errors = 0;

    logic [24:0] x_sb[$];
    logic [15:0] done_sb[$];

    logic        stall_pending = 1'b0;
    logic [24:0] stall_val = '0;

    quadra_arg_gen #(.XW(24), .CW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_step  (cmd_step),
        .cmd_count (cmd_count),
        .abort     (abort),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .x         (x),
        .x_last    (x_last),
        .busy      (busy),
        .done      (done),
        .beats     (beats),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectX(input logic [23:0] val, input logic last);
        x_sb.push_back({last, val});
    endtask

    // mode 0: x_ready always 1; mode 1: x_ready pattern 1,0,0,1 repeating
    task automatic applyStimulus(input logic [23:0] start, input logic [23:0] step,
                                 input logic [15:0] count, input int mode, input int abort_at);
        int hs;
        int cyc;
        int waited;
        hs = 0;
        cyc = 0;
        waited = 0;
        while (!cmd_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!cmd_ready) begin
            checkOutput("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_start = start;
        cmd_step  = step;
        cmd_count = count;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        if (count == 16'd0) begin
            checkOutput("empty_cmd_ready", 32'(cmd_ready), 32'd1);
            checkOutput("empty_x_valid", 32'(x_valid), 32'd0);
            return;
        end
        checkOutput("run_busy", 32'(busy), 32'd1);
        while (cyc < 200) begin
            x_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            abort = (abort_at > 0) && x_valid && x_ready && (hs == abort_at - 1);
            if (x_valid && x_ready) hs++;
            @(posedge clk);
            #1;
            cyc++;
            if (!x_valid) break;
        end
        abort   = 1'b0;
        x_ready = 1'b0;
        if (x_valid) checkOutput("sweep_timeout", 32'(x_valid), 32'd0);
    endtask

    // Monitor: compares each handshaken beat, stall stability and done results
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_pending && x_valid) checkOutput("stall_hold", 32'({x_last, x}), 32'(stall_val));
            stall_pending = 1'b0;
            if (x_valid && x_ready) begin
                if (x_sb.size() == 0) begin
                    checkOutput("unexpected_beat", 32'({x_last, x}), 32'h0);
                    if ({x_last, x} == 25'h0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_beat: got beat, expected none");
                    end
                end else begin
                    checkOutput("x_beat", 32'({x_last, x}), 32'(x_sb.pop_front()));
                end
            end else if (x_valid) begin
                stall_pending = 1'b1;
                stall_val = {x_last, x};
            end
            if (done) begin
                checkOutput("done_x_valid", 32'(x_valid), 32'd0);
                if (done_sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected 0");
                end else begin
                    checkOutput("done_beats", 32'(beats), 32'(done_sb.pop_front()));
                end
            end
        end else begin
            stall_pending = 1'b0;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_start = '0;
        cmd_step = '0;
        cmd_count = '0;
        abort = 1'b0;
        x_ready = 1'b0;
        #3;
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("rst_x_valid", 32'(x_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_beats", 32'(beats), 32'd0);
        checkOutput("rst_sat", 32'(sat), 32'd0);
        checkOutput("rst_x", 32'(x), 32'd0);
        checkOutput("rst_x_last", 32'(x_last), 32'd0);
        #9 rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] basic sweep");
        expectX(24'h000100, 1'b0);
        expectX(24'h000110, 1'b0);
        expectX(24'h000120, 1'b0);
        expectX(24'h000130, 1'b1);
        done_sb.push_back(16'd4);
        applyStimulus(24'h000100, 24'h000010, 16'd4, 0, 0);

        $display("[TB] sweep with backpressure");
        expectX(24'h000100, 1'b0);
        expectX(24'h000110, 1'b0);
        expectX(24'h000120, 1'b0);
        expectX(24'h000130, 1'b1);
        done_sb.push_back(16'd4);
        applyStimulus(24'h000100, 24'h000010, 16'd4, 1, 0);

        $display("[TB] empty sweep");
        done_sb.push_back(16'd0);
        applyStimulus(24'h000ABC, 24'h000001, 16'd0, 0, 0);
        @(posedge clk);
        #1;

        $display("[TB] abort on third beat");
        expectX(24'h000200, 1'b0);
        expectX(24'h000203, 1'b0);
        expectX(24'h000206, 1'b0);
        done_sb.push_back(16'd3);
        applyStimulus(24'h000200, 24'h000003, 16'd10, 0, 3);

        $display("[TB] abort while idle");
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("idle_abort_ready", 32'(cmd_ready), 32'd1);
        checkOutput("idle_abort_busy", 32'(busy), 32'd0);

        $display("[TB] overflow sweep");
        expectX(24'hFFFFF0, 1'b0);
`ifdef QUADRA_ARG_GEN_SAT_EN
        expectX(24'hFFFFFF, 1'b0);
        expectX(24'hFFFFFF, 1'b1);
`else
        expectX(24'h000000, 1'b0);
        expectX(24'h000010, 1'b1);
`endif
        done_sb.push_back(16'd3);
        applyStimulus(24'hFFFFF0, 24'h000010, 16'd3, 0, 0);
`ifdef QUADRA_ARG_GEN_SAT_EN
        checkOutput("sat_flag", 32'(sat), 32'd1);
`else
        checkOutput("sat_flag", 32'(sat), 32'd0);
`endif

        $display("[TB] back-to-back sweeps");
        expectX(24'h000010, 1'b0);
        expectX(24'h000015, 1'b1);
        done_sb.push_back(16'd2);
        applyStimulus(24'h000010, 24'h000005, 16'd2, 0, 0);
        expectX(24'h000700, 1'b1);
        done_sb.push_back(16'd1);
        applyStimulus(24'h000700, 24'h000001, 16'd1, 0, 0);
        checkOutput("sat_cleared", 32'(sat), 32'd0);

        $display("[TB] reset mid-sweep");
        @(posedge clk);
        #1;
        expectX(24'h000500, 1'b0);
        expectX(24'h000501, 1'b0);
        expectX(24'h000502, 1'b0);
        cmd_valid = 1'b1;
        cmd_start = 24'h000500;
        cmd_step = 24'h000001;
        cmd_count = 16'd10;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        x_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_x_valid", 32'(x_valid), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        checkOutput("midrst_beats", 32'(beats), 32'd0);
        checkOutput("midrst_pending_beats", 32'(x_sb.size()), 32'd0);
        x_sb.delete();
        x_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        checkOutput("sb_x_empty", 32'(x_sb.size()), 32'd0);
        checkOutput("sb_done_empty", 32'(done_sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
